// File: rtl/cache_bus_responder.sv
// Bus/snoop responder seen by the L2 cache model: one operation at a time,
// snoop result after SNOOP_LAT cycles, address-derived fill bursts, saturating op counters.
module cache_bus_responder #(
  parameter int SNOOP_LAT = 2,
  parameter int BEATS     = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  output logic             snoop_valid,
  output logic [1:0]       snoop_result,
  output logic             data_valid,
  output logic [31:0]      data_out,
  output logic             data_last,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] read_cnt,
  output logic [CNT_W-1:0] write_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] rwim_cnt,
  output logic [CNT_W-1:0] hitm_cnt
);

  // state | meaning
  // IDLE  | ready for a new operation
  // SNOOP | waiting out snoop latency; strobes result on its last cycle
  // DATA  | driving fill beats (READ/RWIM)
  // DONE  | one-cycle completion strobe
  // ERR   | one-cycle illegal-op strobe
  typedef enum logic [2:0] {IDLE, SNOOP, DATA, DONE, ERR} state_t;

  localparam int              BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]      LAT_LOAD  = 4'(SNOOP_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  state_t         state, state_nx;
  logic [2:0]     op_q;
  logic [31:0]    addr_q;
  logic [3:0]     lat_cnt;
  logic [BW-1:0]  beat;
  logic [1:0]     result_q;
  logic [1:0]     result_dec;
  logic           accept;
  logic           legal;
  logic           fill_op;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign accept     = req_valid && req_ready;
  assign legal      = (req_op >= OP_READ) && (req_op <= OP_RWIM);
  assign fill_op    = (op_q == OP_READ) || (op_q == OP_RWIM);
  assign result_dec = addr_q[1] ? 2'd0 : (addr_q[0] ? 2'd2 : 2'd1);

  assign req_ready    = (state == IDLE);
  assign snoop_valid  = (state == SNOOP) && (lat_cnt == 4'd0);
  // Result is live during the strobe and held afterwards until the next snoop.
  assign snoop_result = snoop_valid ? result_dec : result_q;
  assign data_valid   = (state == DATA);
  assign data_last    = data_valid && (beat == LAST_BEAT);
  assign data_out     = data_valid ? ({addr_q[31:2], 2'b00} + 32'({beat, 2'b00})) : 32'd0;
  assign done         = (state == DONE);
  assign err          = (state == ERR);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = legal ? SNOOP : ERR;
      SNOOP:   if (lat_cnt == 4'd0) state_nx = fill_op ? DATA : DONE;
      DATA:    if (beat == LAST_BEAT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      addr_q    <= 32'd0;
      lat_cnt   <= 4'd0;
      beat      <= '0;
      result_q  <= 2'd0;
      read_cnt  <= '0;
      write_cnt <= '0;
      inv_cnt   <= '0;
      rwim_cnt  <= '0;
      hitm_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        lat_cnt <= LAT_LOAD;
      end else if ((state == SNOOP) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      beat <= ((state == DATA) && (beat != LAST_BEAT)) ? beat + BW'(1) : '0;
      if (snoop_valid) begin
        result_q <= result_dec;
        if (result_dec == 2'd2) hitm_cnt <= sat_inc(hitm_cnt);
      end
      if (accept) begin
        case (req_op)
          OP_READ:  read_cnt  <= sat_inc(read_cnt);
          OP_WRITE: write_cnt <= sat_inc(write_cnt);
          OP_INV:   inv_cnt   <= sat_inc(inv_cnt);
          OP_RWIM:  rwim_cnt  <= sat_inc(rwim_cnt);
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Scoreboard bench for cache_bus_responder: stimulus pushes expected events,
// a negedge monitor pops and compares them against DUT strobes and cycle numbers.
module tb_cache_bus_responder;

  localparam int L  = 2;
  localparam int B  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic          snoop_valid;
  logic [1:0]    snoop_result;
  logic          data_valid;
  logic [31:0]   data_out;
  logic          data_last;
  logic          done;
  logic          err;
  logic [CW-1:0] read_cnt, write_cnt, inv_cnt, rwim_cnt, hitm_cnt;

  cache_bus_responder #(.SNOOP_LAT(L), .BEATS(B), .CNT_W(CW)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result),
    .data_valid(data_valid), .data_out(data_out), .data_last(data_last),
    .done(done), .err(err),
    .read_cnt(read_cnt), .write_cnt(write_cnt), .inv_cnt(inv_cnt),
    .rwim_cnt(rwim_cnt), .hitm_cnt(hitm_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          kind;   // 0 snoop, 1 data, 2 done, 3 err
    logic [31:0] val;
    logic        last;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] beat_log[$];
  int errors = 0;
  int checks = 0;
  int m_rd = 0, m_wr = 0, m_inv = 0, m_rwim = 0, m_hitm = 0;

  function automatic int sat(int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  function automatic exp_t mk(int kind, logic [31:0] val, logic last, int at);
    exp_t e;
    e.kind = kind; e.val = val; e.last = last; e.at = at;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic mon(int kind, logic [31:0] val, logic last);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%h at cycle %0d, expected no event", kind, val, cyc);
      return;
    end
    e = sbq.pop_front();
    if (e.kind != kind || e.val !== val || e.last !== last || e.at != cyc) begin
      errors++;
      $display("FAIL event: got kind=%0d val=%h last=%b cyc=%0d, expected kind=%0d val=%h last=%b cyc=%0d",
               kind, val, last, cyc, e.kind, e.val, e.last, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (rstb) begin
      if (snoop_valid || data_valid)
        check("snoop_data_exclusive", {31'd0, snoop_valid && data_valid}, 32'd0);
      if (snoop_valid) mon(0, {30'd0, snoop_result}, 1'b0);
      if (data_valid) begin
        beat_log.push_back(data_out);
        mon(1, data_out, data_last);
      end
      if (done) mon(2, 32'd0, 1'b0);
      if (err)  mon(3, 32'd0, 1'b0);
    end
  end

  task automatic push_expect(input logic [2:0] op, input logic [31:0] addr, input int t);
    logic [1:0]  r;
    logic [31:0] base;
    if (op == 3'd0 || op > 3'd4) begin
      sbq.push_back(mk(3, 32'd0, 1'b0, t + 1));
      return;
    end
    r = addr[1] ? 2'd0 : (addr[0] ? 2'd2 : 2'd1);
    sbq.push_back(mk(0, {30'd0, r}, 1'b0, t + L));
    if (r == 2'd2) m_hitm = sat(m_hitm);
    case (op)
      3'd1: m_rd   = sat(m_rd);
      3'd2: m_wr   = sat(m_wr);
      3'd3: m_inv  = sat(m_inv);
      default: m_rwim = sat(m_rwim);
    endcase
    if (op == 3'd1 || op == 3'd4) begin
      base = {addr[31:2], 2'b00};
      for (int k = 0; k < B; k++)
        sbq.push_back(mk(1, base + 32'(4 * k), k == B - 1, t + L + 1 + k));
      sbq.push_back(mk(2, 32'd0, 1'b0, t + L + B + 1));
    end else begin
      sbq.push_back(mk(2, 32'd0, 1'b0, t + L + 1));
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input bit hold, output int t);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, expected 1", n);
      req_valid = 1'b0;
      t = 0;
      return;
    end
    t = cyc;
    push_expect(op, addr, t);
    @(posedge clk);
    #1;
    req_valid = hold;
    req_addr  = ~addr;
    if (!hold) req_op = 3'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(req_ready && sbq.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(req_ready && sbq.size() == 0)) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got %0d pending events ready=%b, expected 0 pending and ready", sbq.size(), req_ready);
      sbq.delete();
    end
  endtask

  task automatic check_cnts(string tag);
    check({tag, "_read_cnt"},  32'(read_cnt),  32'(m_rd));
    check({tag, "_write_cnt"}, 32'(write_cnt), 32'(m_wr));
    check({tag, "_inv_cnt"},   32'(inv_cnt),   32'(m_inv));
    check({tag, "_rwim_cnt"},  32'(rwim_cnt),  32'(m_rwim));
    check({tag, "_hitm_cnt"},  32'(hitm_cnt),  32'(m_hitm));
  endtask

  initial begin
    int t, t2;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_strobes", {27'd0, snoop_valid, data_valid, data_last, done, err}, 32'd0);
    check("reset_result", {30'd0, snoop_result}, 32'd0);
    check("reset_data", data_out, 32'd0);
    check_cnts("reset");
    rstb = 1'b1;

    // READ hit with defaults
    beat_log.delete();
    issue(3'd1, 32'h0000_1000, 1'b0, t);
    wait_idle();
    check("rd_beats", beat_log.size(), 32'd4);
    if (beat_log.size() == 4) begin
      check("rd_beat0", beat_log[0], 32'h0000_1000);
      check("rd_beat3", beat_log[3], 32'h0000_100C);
    end
    check_cnts("read");

    // RWIM with HITM
    beat_log.delete();
    issue(3'd4, 32'h0000_2001, 1'b0, t);
    wait_idle();
    if (beat_log.size() == 4) check("rwim_beat0", beat_log[0], 32'h0000_2000);
    check("rwim_hitm_cnt", 32'(hitm_cnt), 32'd1);
    check("snoop_held", {30'd0, snoop_result}, 32'd2);
    check_cnts("rwim");

    // INVALIDATE, NOHIT, no data
    issue(3'd3, 32'h0000_0003, 1'b0, t);
    wait_idle();
    check_cnts("inv");

    // Address wrap on fill
    beat_log.delete();
    issue(3'd1, 32'hFFFF_FFF8, 1'b0, t);
    wait_idle();
    check("wrap_beats", beat_log.size(), 32'd4);
    if (beat_log.size() == 4) begin
      check("wrap_beat0", beat_log[0], 32'hFFFF_FFF8);
      check("wrap_beat1", beat_log[1], 32'hFFFF_FFFC);
      check("wrap_beat2", beat_log[2], 32'h0000_0000);
      check("wrap_beat3", beat_log[3], 32'h0000_0004);
    end

    // Illegal op
    issue(3'd5, 32'h0000_0100, 1'b0, t);
    @(negedge clk);
    check("illegal_ready_t1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("illegal_ready_t2", {31'd0, req_ready}, 32'd1);
    wait_idle();
    check_cnts("illegal");

    // Back-to-back WRITE then READ with req_valid held
    issue(3'd2, 32'h0000_0010, 1'b1, t);
    issue(3'd1, 32'h0000_0020, 1'b0, t2);
    check("b2b_accept_cycle", 32'(t2 - t), 32'(L + 2));
    wait_idle();
    check_cnts("b2b");

    // Reset during beat 2 of a fill
    issue(3'd1, 32'h0000_1000, 1'b0, t);
    while (cyc < t + L + 3) @(negedge clk);
    #1 rstb = 1'b0;
    #1;
    sbq.delete();
    m_rd = 0; m_wr = 0; m_inv = 0; m_rwim = 0; m_hitm = 0;
    check("midrst_strobes", {27'd0, snoop_valid, data_valid, data_last, done, err}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_data", data_out, 32'd0);
    check_cnts("midrst");
    @(negedge clk);
    rstb = 1'b1;

    beat_log.delete();
    issue(3'd1, 32'h0000_0040, 1'b0, t);
    wait_idle();
    if (beat_log.size() == 4) check("fresh_beat3", beat_log[3], 32'h0000_004C);
    check("fresh_read_cnt", 32'(read_cnt), 32'd1);

    // Saturation of write_cnt (2^CW writes)
    for (int i = 0; i < (1 << CW); i++)
      issue(3'd2, 32'h0000_0002, (i != (1 << CW) - 1), t);
    wait_idle();
    check("write_cnt_sat", 32'(write_cnt), 32'h0000_00FF);
    check_cnts("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish by %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_bus_responder.md
Name: cache_bus_responder

Overview:
- Models the external bus and the other caches seen by the L2 cache model.
- Accepts one bus operation at a time from the cache (READ, WRITE, INVALIDATE, RWIM).
- Returns a snoop result and, for line fills, a burst of address-derived data beats.
- Keeps per-operation counters for comparison against the expected trace results.

Parameters:
- SNOOP_LAT, 2: cycles from accept to snoop result; legal range 1..15.
- BEATS, 4: data beats per line fill for READ/RWIM; legal range 1..16.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- req_valid  in  1  cache presents a bus operation.
- req_ready  out  1  responder can accept an operation.
- req_op  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; others illegal.
- req_addr  in  32  byte address of the operation.
- snoop_valid  out  1  one-cycle strobe qualifying snoop_result.
- snoop_result  out  2  0=NOHIT, 1=HIT, 2=HITM.
- data_valid  out  1  fill data beat valid.
- data_out  out  32  fill data beat.
- data_last  out  1  final beat of a fill.
- done  out  1  one-cycle strobe marking operation complete.
- err  out  1  one-cycle strobe for an illegal op.
- read_cnt, write_cnt, inv_cnt, rwim_cnt  out  CNT_W each  accepted-op counters.
- hitm_cnt  out  CNT_W  number of HITM snoop results issued.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low on rstb.
- Reset values:
  - FSM in IDLE; all strobes (snoop_valid, data_valid, data_last, done, err) = 0.
  - snoop_result = 0, data_out = 0, all counters = 0.
  - req_ready is decoded as state==IDLE, so it reads 1 while in reset.
- Reset mid-operation: abort immediately to IDLE; no done is issued for the aborted op.
- FSM states: IDLE, SNOOP, DATA, DONE, ERR.
- Handshake:
  - Accept occurs at a rising edge with req_valid & req_ready (cycle T).
  - req_op and req_addr are latched at T; later input changes are ignored.
  - req_ready = 0 from T+1 until the cycle after done.
- Illegal op (0, 5, 6, 7):
  - IDLE->ERR at T; err = 1 at T+1; back to IDLE at T+2.
  - No snoop result, no done, no counter change.
- Legal op:
  - IDLE->SNOOP at T; a down-counter of SNOOP_LAT is loaded.
  - snoop_valid = 1 for exactly one cycle at T+SNOOP_LAT.
  - Snoop result from addr_q[1:0]: 00 HIT, 01 HITM, 1x NOHIT. The result is held on snoop_result until the next snoop.
- READ/RWIM:
  - SNOOP->DATA; beats k = 0..BEATS-1 are driven at T+SNOOP_LAT+1+k.
  - data_out = {addr_q[31:2],2'b00} + 4*k, modulo 2^32 (wraps past 0xFFFFFFFC).
  - data_last on beat BEATS-1 only.
  - done at T+SNOOP_LAT+BEATS+1.
- WRITE/INVALIDATE: SNOOP->DONE; no data; done at T+SNOOP_LAT+1.
- After done: DONE->IDLE; req_ready = 1 the following cycle, so the earliest back-to-back accept is at done+1.
- Counters:
  - The matching op counter increments at the accept edge.
  - hitm_cnt increments with the HITM snoop strobe.
  - All counters saturate at 2^CNT_W-1 with no wrap.
- Simultaneous events: req_valid asserted while req_ready = 0 is ignored (not queued); the cache must hold its request.
- data_valid and snoop_valid are never high in the same cycle.

Test Plan:
- Reset: assert rstb=0 mid-fill (during beat 2) -> all strobes 0 and counters 0 within the same cycle; req_ready=1; the next READ behaves as fresh.
- READ hit, defaults: READ, addr 0x00001000, accepted at T -> snoop_valid at T+2 with HIT; data 0x1000, 0x1004, 0x1008, 0x100C at T+3..T+6; data_last at T+6; done at T+7; read_cnt=1.
- HITM and no data:
  - RWIM to 0x00002001 -> HITM at T+2, hitm_cnt=1, 4 beats from 0x2000.
  - INVALIDATE to 0x3 -> NOHIT, no data_valid, done at T+3, inv_cnt=1.
- Wrap-around and parameters: READ at 0xFFFFFFF8 with BEATS=4 -> data 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Illegal op: req_op=5 -> err at T+1, req_ready=1 at T+2, no snoop, all counters unchanged.
- Back-to-back and saturation:
  - WRITE then READ with req_valid held high -> second accept exactly at done+1.
  - Preload-by-stimulus 65535 WRITEs then one more -> write_cnt stays 0xFFFF.
